iomem_initiator: RTL and testbench

//  Single-outstanding bus initiator for the iomem valid/ready memory interface.

---
 rtl/iomem_initiator.sv | 170 +++++++++++++++++
 tb/tb_iomem_initiator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_initiator.sv
// iomem_initiator: single-outstanding initiator bridging a valid/ready
// command/response pair onto the iomem valid/ready memory bus.
// One command is in flight at a time. A misaligned address is answered
// with an error and never reaches the bus. A bus request that is not
// completed within TIMEOUT_CYCLES is abandoned with an error.
module iomem_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk_i,
    input  logic        rst_n,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_wstrb_i,

    output logic        iomem_valid_o,
    input  logic        iomem_ready_i,
    output logic [31:0] iomem_addr_o,
    output logic [31:0] iomem_wdata_o,
    output logic [3:0]  iomem_wstrb_o,
    input  logic [31:0] iomem_rdata_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_write_o,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Last counter value before the request is abandoned; the counter
    // starts at 0 in the first REQ cycle, so valid is high exactly
    // TIMEOUT_CYCLES cycles on a timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Decoded events for the current cycle
    logic accept;
    logic misalign;
    logic bus_done;
    logic timeout;

    // Command latched at accept, held stable for the whole transaction
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // Response payload, held while the response waits for rsp_ready_i
    logic [31:0] rdata_q;
    logic        err_q;
    logic        write_q;

    // Force a bus/response field to zero whenever its qualifier is low,
    // so unqualified cycles never expose stale transaction data.
    function automatic logic [31:0] gate32(input logic en, input logic [31:0] val);
        return en ? val : 32'd0;
    endfunction

    function automatic logic [3:0] gate4(input logic en, input logic [3:0] val);
        return en ? val : 4'd0;
    endfunction

    // State and timeout counter register; only control state is reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state decode: accept, bus completion, timeout and response handshake.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        misalign  = 1'b0;
        bus_done  = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept = 1'b1;
                    if (cmd_addr_i[1:0] != 2'b00) begin
                        // Answered locally; the bus never sees this command.
                        misalign  = 1'b1;
                        state_nxt = RSP;
                    end else begin
                        state_nxt = REQ;
                        cnt_nxt   = '0;
                    end
                end
            end
            REQ: begin
                if (iomem_ready_i) begin
                    bus_done  = 1'b1;
                    state_nxt = RSP;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = RSP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RSP: begin
                // Leaving through IDLE guarantees the bus sees valid low
                // for at least the RSP and IDLE cycles between requests.
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch and response capture; data path carries no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            wstrb_q <= cmd_wstrb_i;
            write_q <= |cmd_wstrb_i;
        end
        if (accept && misalign) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
        end else if (bus_done) begin
            // Writes report zero data even if the responder drives rdata.
            rdata_q <= (wstrb_q == 4'b0000) ? iomem_rdata_i : 32'd0;
            err_q   <= 1'b0;
        end else if (timeout) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
        end
    end

    // Output decode: all outputs derive from registered state, gated so that
    // reset and idle cycles present zeros.
    assign cmd_ready_o   = (state == IDLE);
    assign iomem_valid_o = (state == REQ);
    assign rsp_valid_o   = (state == RSP);
    assign busy_o        = (state != IDLE);

    assign iomem_addr_o  = gate32(iomem_valid_o, addr_q);
    assign iomem_wdata_o = gate32(iomem_valid_o, wdata_q);
    assign iomem_wstrb_o = gate4(iomem_valid_o, wstrb_q);

    assign rsp_rdata_o   = gate32(rsp_valid_o, rdata_q);
    assign rsp_err_o     = rsp_valid_o & err_q;
    assign rsp_write_o   = rsp_valid_o & write_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// tb_iomem_initiator: directed, table-driven bench for iomem_initiator with
// a cycle-stepped responder model and hand-written corner-case sequences.
module tb_iomem_initiator;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_wstrb_i;
    logic        iomem_valid_o;
    logic        iomem_ready_i;
    logic [31:0] iomem_addr_o;
    logic [31:0] iomem_wdata_o;
    logic [3:0]  iomem_wstrb_o;
    logic [31:0] iomem_rdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_write_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    iomem_initiator #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .cmd_wstrb_i   (cmd_wstrb_i),
        .iomem_valid_o (iomem_valid_o),
        .iomem_ready_i (iomem_ready_i),
        .iomem_addr_o  (iomem_addr_o),
        .iomem_wdata_o (iomem_wdata_o),
        .iomem_wstrb_o (iomem_wstrb_o),
        .iomem_rdata_i (iomem_rdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_write_o   (rsp_write_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // delay: cycles of valid before ready (0 = same cycle), -1 = never.
    // exp_vcyc: cycles iomem_valid_o is high, also accept-to-response latency.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;
        logic [31:0] bus_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_write;
        int          exp_vcyc;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction: offer the command, play responder, then hold the
    // response for 'hold' cycles (optionally with a stray late ready) before
    // consuming it.
    task automatic do_txn(input vec_t v, input int hold, input logic late);
        int vcnt;
        int cyc;
        cmd_valid_i = 1'b1;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        cmd_wstrb_i = v.wstrb;
        chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        step();
        cmd_valid_i = 1'b0;
        vcnt = 0;
        cyc  = 0;
        while (!rsp_valid_o && cyc < 200) begin
            if (iomem_valid_o) begin
                vcnt++;
                if (vcnt == 1) begin
                    chk("bus_addr", iomem_addr_o, v.addr);
                    chk("bus_wdata", iomem_wdata_o, v.wdata);
                    chk("bus_wstrb", 32'(iomem_wstrb_o), 32'(v.wstrb));
                    chk("cmd_ready_req", 32'(cmd_ready_o), 32'd0);
                end
                iomem_ready_i = (v.delay >= 0) && (vcnt - 1 == v.delay);
                iomem_rdata_i = iomem_ready_i ? v.bus_rdata : 32'hBAD0_BAD0;
            end else begin
                iomem_ready_i = 1'b0;
                iomem_rdata_i = 32'h0;
            end
            step();
            cyc++;
        end
        iomem_ready_i = 1'b0;
        iomem_rdata_i = 32'h0;
        chk("rsp_arrived", 32'(rsp_valid_o), 32'd1);
        chk("valid_cycles", 32'(vcnt), 32'(v.exp_vcyc));
        chk("rsp_latency", 32'(cyc), 32'(v.exp_vcyc));
        chk("bus_addr_idle", iomem_addr_o, 32'h0);
        for (int h = 0; h < hold; h++) begin
            chk("hold_rdata", rsp_rdata_o, v.exp_rdata);
            chk("hold_err", 32'(rsp_err_o), 32'(v.exp_err));
            chk("hold_valid", 32'(rsp_valid_o), 32'd1);
            chk("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
            cmd_valid_i   = 1'b1;
            cmd_addr_i    = 32'h4000_0100;
            cmd_wstrb_i   = 4'b0000;
            iomem_ready_i = late;
            iomem_rdata_i = 32'hFFFF_FFFF;
            step();
        end
        cmd_valid_i = 1'b0;
        chk("rsp_rdata", rsp_rdata_o, v.exp_rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
        chk("rsp_write", 32'(rsp_write_o), 32'(v.exp_write));
        chk("iomem_valid_in_rsp", 32'(iomem_valid_o), 32'd0);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i   = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("post_iomem_valid", 32'(iomem_valid_o), 32'd0);
        iomem_ready_i = 1'b0;
        iomem_rdata_i = 32'h0;
    endtask

    initial begin
        vec_t bp;
        logic vhist [12];
        logic rhist [12];
        logic [31:0] dhist [12];

        //           addr          wdata         wstrb    dly bus_rdata     exp_rdata     err   wr    vcyc
        vecs[0] = '{32'h4000_0010, 32'h0000_0000, 4'b0000, 16, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 17};
        vecs[1] = '{32'h4000_0020, 32'h1234_5678, 4'b0011, 0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1};
        vecs[2] = '{32'h3000_0000, 32'h0000_0000, 4'b0000, -1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 64};
        vecs[3] = '{32'h4000_0002, 32'h0000_0000, 4'b0000, 0,  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0};
        vecs[4] = '{32'h4000_0001, 32'hCAFE_F00D, 4'b1111, 0,  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 0};
        vecs[5] = '{32'h4000_0004, 32'h0000_0000, 4'b0000, 3,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 1'b0, 4};
        vecs[6] = '{32'h4000_0008, 32'h8765_4321, 4'b1111, 63, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b1, 64};
        bp      = '{32'h4000_0014, 32'h0000_0000, 4'b0000, 2,  32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 3};

        rst_n         = 1'b0;
        cmd_valid_i   = 1'b0;
        cmd_addr_i    = 32'h0;
        cmd_wdata_i   = 32'h0;
        cmd_wstrb_i   = 4'h0;
        iomem_ready_i = 1'b0;
        iomem_rdata_i = 32'h0;
        rsp_ready_i   = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_iomem_valid", 32'(iomem_valid_o), 32'd0);
        chk("rst_iomem_addr", iomem_addr_o, 32'h0);
        chk("rst_iomem_wdata", iomem_wdata_o, 32'h0);
        chk("rst_iomem_wstrb", 32'(iomem_wstrb_o), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_rsp_write", 32'(rsp_write_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i], 0, 1'b0);
        end

        // Response backpressure for 10 cycles with a competing command offered
        do_txn(bp, 10, 1'b0);

        // Timeout followed by a late ready while the error response waits
        do_txn(vecs[2], 3, 1'b1);
        do_txn(vecs[5], 0, 1'b0);

        // Back-to-back commands with an always-ready responder and consumer:
        // valid pattern must be 1,0,0 repeating
        cmd_valid_i   = 1'b1;
        cmd_addr_i    = 32'h4000_0000;
        cmd_wstrb_i   = 4'b0000;
        iomem_ready_i = 1'b1;
        iomem_rdata_i = 32'h0000_0011;
        rsp_ready_i   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            vhist[i] = iomem_valid_o;
            rhist[i] = rsp_valid_o;
            dhist[i] = rsp_rdata_o;
        end
        cmd_valid_i   = 1'b0;
        iomem_ready_i = 1'b0;
        rsp_ready_i   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("b2b_valid", 32'(vhist[i]), (i % 3 == 0) ? 32'd1 : 32'd0);
            chk("b2b_rsp_valid", 32'(rhist[i]), (i % 3 == 1) ? 32'd1 : 32'd0);
            chk("b2b_rsp_rdata", dhist[i], (i % 3 == 1) ? 32'h0000_0011 : 32'h0);
        end
        step();
        chk("b2b_idle", 32'(busy_o), 32'd0);

        // Reset in the middle of a bus request, then a late ready
        cmd_valid_i = 1'b1;
        cmd_addr_i  = 32'h4000_0010;
        cmd_wstrb_i = 4'b0000;
        step();
        cmd_valid_i = 1'b0;
        step();
        step();
        chk("midrst_req_valid", 32'(iomem_valid_o), 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(iomem_valid_o), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        rst_n         = 1'b1;
        iomem_ready_i = 1'b1;
        iomem_rdata_i = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("late_ready_no_rsp", 32'(rsp_valid_o), 32'd0);
            chk("late_ready_no_valid", 32'(iomem_valid_o), 32'd0);
        end
        iomem_ready_i = 1'b0;
        iomem_rdata_i = 32'h0;

        // Normal operation resumes after the reset
        do_txn(vecs[0], 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
